// File: rtl/lynxTypes.sv
// Shared widths and helpers for the benchmark request scheduler.
//   LEN_BITS   - request length width
//   VADDR_BITS - virtual address width
//   PID_BITS   - process id width
//   CNT_BITS   - width of repetition / completion counters
package lynxTypes;

  localparam int LEN_BITS   = 28;
  localparam int VADDR_BITS = 48;
  localparam int PID_BITS   = 6;
  localparam int CNT_BITS   = 32;

  function automatic logic [CNT_BITS-1:0] min_cnt(input logic [CNT_BITS-1:0] a,
                                                  input logic [CNT_BITS-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/perf_fpga_bench_channel.sv
// One request channel of the benchmark scheduler: tracks issued requests,
// outstanding requests and completions, and drives the request valid.
// Ports:
//   aclk, aresetn     - clock, asynchronous active-low reset
//   clear             - synchronous clear of all counters (soft reset or new run)
//   enable            - channel is active in the current run
//   n_reps            - number of requests to issue this run
//   req_valid/ready   - request handshake
//   req_last          - current request is the final one of the run
//   cmpl              - one-cycle completion pulse
//   cmpl_count        - completions counted so far
//   all_done_next     - completion count reaches n_reps after this cycle
module perf_fpga_bench_channel
  import lynxTypes::*;
#(
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                clear,
  input  logic                enable,
  input  logic [CNT_BITS-1:0] n_reps,
  output logic                req_valid,
  input  logic                req_ready,
  output logic                req_last,
  input  logic                cmpl,
  output logic [CNT_BITS-1:0] cmpl_count,
  output logic                all_done_next
);

  // One extra bit so the counter can hold MAX_OUTSTANDING itself.
  localparam int OUT_BITS = $clog2(MAX_OUTSTANDING) + 1;

  logic [CNT_BITS-1:0] issued_reg;
  logic [CNT_BITS-1:0] cmpl_reg;
  logic [OUT_BITS-1:0] outstanding_reg;
  logic                accept;
  logic                cmpl_hit;

  // Valid depends only on registered state, and the counters it depends on
  // only move on a handshake, so valid and payload cannot drop before ready.
  assign req_valid = enable && (issued_reg < n_reps) &&
                     (outstanding_reg < OUT_BITS'(MAX_OUTSTANDING));
  assign req_last  = req_valid && (issued_reg == n_reps - 1'b1);
  assign accept    = req_valid && req_ready;
  // Stray completions (nothing in flight, or channel idle) are dropped.
  assign cmpl_hit  = enable && cmpl && (outstanding_reg != '0);

  assign cmpl_count    = cmpl_reg;
  assign all_done_next = (cmpl_reg + {{(CNT_BITS-1){1'b0}}, cmpl_hit}) == n_reps;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      issued_reg      <= '0;
      cmpl_reg        <= '0;
      outstanding_reg <= '0;
    end else if (clear) begin
      issued_reg      <= '0;
      cmpl_reg        <= '0;
      outstanding_reg <= '0;
    end else begin
      if (accept)   issued_reg <= issued_reg + 1'b1;
      if (cmpl_hit) cmpl_reg   <= cmpl_reg + 1'b1;
      case ({accept, cmpl_hit})
        2'b10:   outstanding_reg <= outstanding_reg + 1'b1;
        2'b01:   outstanding_reg <= outstanding_reg - 1'b1;
        default: outstanding_reg <= outstanding_reg;
      endcase
    end
  end

endmodule

// File: rtl/perf_fpga_bench_scheduler.sv
// Benchmark request scheduler: on a start from the control registers it
// issues n_reps read and/or write requests, counts completions and measures
// the run duration in cycles.
// Ports:
//   aclk, aresetn                  - clock, asynchronous active-low reset
//   bench_reset                    - synchronous soft clear
//   bench_n_reps, bench_req_ctrl   - run length and channel enables (start)
//   bench_req_len_A/B, vaddr_A/B   - read (A) / write (B) request payload
//   bench_req_pid                  - PID attached to every request
//   req_accepted                   - one-cycle pulse after a start is latched
//   bench_done, bench_timer        - completed repetitions, run cycles
//   rd_req_* / wr_req_*            - request handshake and payload
//   rd_cmpl / wr_cmpl              - completion pulses
module perf_fpga_bench_scheduler
  import lynxTypes::*;
#(
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  bench_reset,
  input  logic [31:0]           bench_n_reps,
  input  logic [1:0]            bench_req_ctrl,
  input  logic [LEN_BITS-1:0]   bench_req_len_A,
  input  logic [LEN_BITS-1:0]   bench_req_len_B,
  input  logic [VADDR_BITS-1:0] bench_req_vaddr_A,
  input  logic [VADDR_BITS-1:0] bench_req_vaddr_B,
  input  logic [PID_BITS-1:0]   bench_req_pid,
  output logic                  req_accepted,
  output logic [31:0]           bench_done,
  output logic [63:0]           bench_timer,
  output logic                  rd_req_valid,
  input  logic                  rd_req_ready,
  output logic [VADDR_BITS-1:0] rd_req_vaddr,
  output logic [LEN_BITS-1:0]   rd_req_len,
  output logic [PID_BITS-1:0]   rd_req_pid,
  output logic                  rd_req_last,
  input  logic                  rd_cmpl,
  output logic                  wr_req_valid,
  input  logic                  wr_req_ready,
  output logic [VADDR_BITS-1:0] wr_req_vaddr,
  output logic [LEN_BITS-1:0]   wr_req_len,
  output logic [PID_BITS-1:0]   wr_req_pid,
  output logic                  wr_req_last,
  input  logic                  wr_cmpl
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t                state_reg, state_next;
  logic [1:0]            ctrl_reg;
  logic [CNT_BITS-1:0]   n_reps_reg;
  logic [LEN_BITS-1:0]   len_a_reg, len_b_reg;
  logic [VADDR_BITS-1:0] vaddr_a_reg, vaddr_b_reg;
  logic [PID_BITS-1:0]   pid_reg;
  logic                  req_accepted_reg;
  logic [63:0]           timer_reg;

  logic                  start;
  logic                  chan_clear;
  logic                  run_done_next;
  logic                  rd_enable, wr_enable;
  logic [CNT_BITS-1:0]   rd_cmpl_count, wr_cmpl_count;
  logic                  rd_done_next, wr_done_next;

  // Soft reset wins over a start presented in the same cycle.
  assign start      = (state_reg != ST_RUN) && (bench_req_ctrl != 2'b00) && !bench_reset;
  assign chan_clear = bench_reset || start;
  assign rd_enable  = (state_reg == ST_RUN) && ctrl_reg[0];
  assign wr_enable  = (state_reg == ST_RUN) && ctrl_reg[1];

  // Uses the post-cycle completion counts so the timer stops exactly on the
  // cycle that samples the final completion.
  assign run_done_next = (!ctrl_reg[0] || rd_done_next) && (!ctrl_reg[1] || wr_done_next);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (bench_reset) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: if (start) state_next = ST_RUN;
        ST_RUN:           if (run_done_next) state_next = ST_DONE;
        default:          state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ctrl_reg         <= '0;
      n_reps_reg       <= '0;
      len_a_reg        <= '0;
      len_b_reg        <= '0;
      vaddr_a_reg      <= '0;
      vaddr_b_reg      <= '0;
      pid_reg          <= '0;
      req_accepted_reg <= 1'b0;
      timer_reg        <= '0;
    end else if (bench_reset) begin
      ctrl_reg         <= '0;
      n_reps_reg       <= '0;
      len_a_reg        <= '0;
      len_b_reg        <= '0;
      vaddr_a_reg      <= '0;
      vaddr_b_reg      <= '0;
      pid_reg          <= '0;
      req_accepted_reg <= 1'b0;
      timer_reg        <= '0;
    end else begin
      req_accepted_reg <= start;
      if (start) begin
        ctrl_reg    <= bench_req_ctrl;
        n_reps_reg  <= bench_n_reps;
        len_a_reg   <= bench_req_len_A;
        len_b_reg   <= bench_req_len_B;
        vaddr_a_reg <= bench_req_vaddr_A;
        vaddr_b_reg <= bench_req_vaddr_B;
        pid_reg     <= bench_req_pid;
        timer_reg   <= '0;
      end else if (state_reg == ST_RUN) begin
        timer_reg <= timer_reg + 64'd1;
      end
    end
  end

  perf_fpga_bench_channel #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_rd_chan (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .clear         (chan_clear),
    .enable        (rd_enable),
    .n_reps        (n_reps_reg),
    .req_valid     (rd_req_valid),
    .req_ready     (rd_req_ready),
    .req_last      (rd_req_last),
    .cmpl          (rd_cmpl),
    .cmpl_count    (rd_cmpl_count),
    .all_done_next (rd_done_next)
  );

  perf_fpga_bench_channel #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_wr_chan (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .clear         (chan_clear),
    .enable        (wr_enable),
    .n_reps        (n_reps_reg),
    .req_valid     (wr_req_valid),
    .req_ready     (wr_req_ready),
    .req_last      (wr_req_last),
    .cmpl          (wr_cmpl),
    .cmpl_count    (wr_cmpl_count),
    .all_done_next (wr_done_next)
  );

  // Completion counts are registered, so this reflects a completion on the
  // cycle after it was sampled; the counts hold in DONE.
  always_comb begin
    bench_done = '0;
    case (ctrl_reg)
      2'b01:   bench_done = rd_cmpl_count;
      2'b10:   bench_done = wr_cmpl_count;
      2'b11:   bench_done = min_cnt(rd_cmpl_count, wr_cmpl_count);
      default: bench_done = '0;
    endcase
  end

  assign req_accepted = req_accepted_reg;
  assign bench_timer  = timer_reg;
  assign rd_req_vaddr = vaddr_a_reg;
  assign rd_req_len   = len_a_reg;
  assign rd_req_pid   = pid_reg;
  assign wr_req_vaddr = vaddr_b_reg;
  assign wr_req_len   = len_b_reg;
  assign wr_req_pid   = pid_reg;

endmodule

// File: doc/perf_fpga_bench_scheduler.md
PERF_FPGA_BENCH_SCHEDULER -- requirements
Module: perf_fpga_bench_scheduler

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 16, maximum in-flight requests per channel (power of two, 2..256).
REQ-002 SHALL have port aclk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port aresetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port bench_reset  input  1  soft clear pulse from control registers.
REQ-005 SHALL have port bench_n_reps  input  32  requests to issue per enabled channel.
REQ-006 SHALL have port bench_req_ctrl  input  2  bit0 enables the read channel, bit1 enables the write channel; nonzero starts a run.
REQ-007 SHALL have ports bench_req_len_A/bench_req_len_B  input  LEN_BITS  read/write request lengths.
REQ-008 SHALL have ports bench_req_vaddr_A/bench_req_vaddr_B  input  VADDR_BITS  read/write virtual addresses.
REQ-009 SHALL have port bench_req_pid  input  PID_BITS  PID attached to every request.
REQ-010 SHALL have port req_accepted  output  1  one-cycle pulse when a start is latched.
REQ-011 SHALL have port bench_done  output  32  completed repetitions.
REQ-012 SHALL have port bench_timer  output  64  run duration in cycles.
REQ-013 SHALL have ports rd_req_valid/wr_req_valid  output  1  and rd_req_ready/wr_req_ready  input  1  for request handshakes.
REQ-014 SHALL have ports rd_req_vaddr/wr_req_vaddr (VADDR_BITS), rd_req_len/wr_req_len (LEN_BITS), rd_req_pid/wr_req_pid (PID_BITS), rd_req_last/wr_req_last (1)  output  request payload.
REQ-015 SHALL have ports rd_cmpl/wr_cmpl  input  1  one-cycle completion pulse per finished request.

Function
REQ-016 SHALL implement FSM IDLE -> RUN -> DONE; DONE behaves as IDLE for starts but holds results.
REQ-017 In IDLE/DONE with bench_req_ctrl != 0, SHALL latch ctrl, n_reps, lengths, addresses, pid; pulse req_accepted next cycle; clear bench_done, bench_timer, all counters; enter RUN.
REQ-018 With latched n_reps == 0, SHALL go RUN -> DONE after one cycle, issuing no requests, bench_done = 0.
REQ-019 In RUN, each enabled channel SHALL assert valid while issued < n_reps and outstanding < MAX_OUTSTANDING; disabled channels keep valid low.
REQ-020 Once valid is asserted, payload SHALL stay stable and valid SHALL stay high until ready (no withdrawal).
REQ-021 Payload SHALL be latched vaddr/len/pid; req_last SHALL be 1 only on the n_reps-th request.
REQ-022 Outstanding counter SHALL +1 on accepted request, -1 on cmpl, unchanged when both occur in one cycle; cmpl with outstanding 0 SHALL be ignored.
REQ-023 bench_done SHALL equal the enabled channel's completion count, or the minimum of both counts when both are enabled, updated the cycle after the completion.
REQ-024 bench_timer SHALL increment every RUN cycle, including the cycle the final completion is sampled, then freeze.
REQ-025 RUN SHALL exit to DONE when every enabled channel has n_reps completions.
REQ-026 bench_req_ctrl changes during RUN SHALL be ignored.
REQ-027 Counters SHALL be 32 bits and SHALL not wrap within a run.

Reset
REQ-028 aresetn low SHALL asynchronously force IDLE, valids 0, req_accepted 0, bench_done 0, bench_timer 0, payload 0, counters 0.
REQ-029 bench_reset SHALL synchronously do the same, with priority over a same-cycle start; in-flight completions afterwards SHALL be ignored.

Structure
REQ-030 LEN_BITS, VADDR_BITS, PID_BITS SHALL come from lynxTypes; the FSM state enum SHALL be local.
REQ-031 One sub-module, perf_fpga_bench_channel (issue/outstanding/completion counters, valid/ready), SHALL be instantiated twice.

Verification
REQ-032 ctrl=01, n_reps=4, ready=1, cmpl 3 cycles after each accept -> 4 rd requests, last on 4th, bench_done=4, DONE, wr_req_valid never 1.
REQ-033 ctrl=11, n_reps=8, wr_cmpl delayed 20 cycles -> bench_done tracks rd/wr minimum, ends 8.
REQ-034 MAX_OUTSTANDING=2, no cmpl for 50 cycles -> exactly 2 accepted requests, then valid low.
REQ-035 ready low for 10 cycles while valid high -> valid and payload constant throughout.
REQ-036 bench_reset mid-run after 3 of 10 -> IDLE next cycle, bench_done=0, later cmpl pulses ignored.
REQ-037 ctrl=10, n_reps=0 -> req_accepted pulse, no requests, DONE, bench_done=0.
